// File: rtl/ahbl_stream_slave_if.sv
// Bus bundle for ahbl_stream_slave: AHB-Lite responder signals plus the TX/RX word streams.
// The master modport is the view of the interconnect and stream endpoints that drive the block.
interface ahbl_stream_slave_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic        HREADY;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
        input  tx_ready, rx_data, rx_valid,
        output HRDATA, HREADYOUT, HRESP,
        output tx_data, tx_valid, rx_ready
    );

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
        output tx_ready, rx_data, rx_valid,
        input  HRDATA, HREADYOUT, HRESP,
        input  tx_data, tx_valid, rx_ready
    );
endinterface

// File: rtl/ahbl_stream_slave.sv
// AHB-Lite responder bridging bus writes into a TX stream FIFO and an RX stream FIFO into bus reads.
// Bus outputs decode registered state and counts only, so no input reaches an output combinationally.
module ahbl_stream_slave #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    ahbl_stream_slave_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT  = CW'(DEPTH);
    localparam logic [7:0]    TIMEOUT_CNT = 8'(TIMEOUT);
    localparam logic [7:0]    ADDR_DATA   = 8'h00;
    localparam logic [7:0]    ADDR_STATUS = 8'h04;
    localparam logic [7:0]    ADDR_CTRL   = 8'h08;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DPHASE,
        S_WAIT,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t      r_state;
    logic [7:0]  r_addr;
    logic        r_write;
    logic [2:0]  r_size;
    logic [7:0]  r_waitCnt;

    logic [31:0]   r_txMem [DEPTH];
    logic [AW-1:0] r_txRd;
    logic [AW-1:0] r_txWr;
    logic [CW-1:0] r_txCount;
    logic [31:0]   r_rxMem [DEPTH];
    logic [AW-1:0] r_rxRd;
    logic [AW-1:0] r_rxWr;
    logic [CW-1:0] r_rxCount;

    logic        w_capture;
    logic        w_badSize;
    logic        w_dataPhase;
    logic        w_isData;
    logic        w_isStatus;
    logic        w_isCtrl;
    logic        w_ready;
    logic        w_resp;
    logic        w_complete;
    logic [7:0]  w_waitNext;
    logic        w_txFull;
    logic        w_txEmpty;
    logic        w_rxFull;
    logic        w_rxEmpty;
    logic        w_txPush;
    logic        w_txPop;
    logic        w_txFlush;
    logic        w_rxPush;
    logic        w_rxPop;
    logic        w_rxFlush;
    logic [7:0]  w_txLevel;
    logic [7:0]  w_rxLevel;
    logic [31:0] w_status;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_unused    = ^{bus.HADDR[31:8], bus.HTRANS[0]};

    assign w_capture   = bus.HSEL && bus.HTRANS[1] && bus.HREADY;
    assign w_badSize   = (bus.HADDR[7:0] == ADDR_DATA) && (bus.HSIZE != 3'd2);
    assign w_dataPhase = (r_state == S_DPHASE) || (r_state == S_WAIT);
    assign w_isData    = (r_addr == ADDR_DATA);
    assign w_isStatus  = (r_addr == ADDR_STATUS);
    assign w_isCtrl    = (r_addr == ADDR_CTRL);
    assign w_complete  = w_dataPhase && w_ready;
    assign w_waitNext  = r_waitCnt + 8'd1;

    assign w_txFull    = (r_txCount == FULL_COUNT);
    assign w_txEmpty   = (r_txCount == '0);
    assign w_rxFull    = (r_rxCount == FULL_COUNT);
    assign w_rxEmpty   = (r_rxCount == '0);

    assign w_txPush    = w_complete && w_isData && r_write;
    assign w_txPop     = !w_txEmpty && bus.tx_ready;
    assign w_txFlush   = w_complete && w_isCtrl && r_write && bus.HWDATA[0];
    assign w_rxPush    = bus.rx_valid && !w_rxFull;
    assign w_rxPop     = w_complete && w_isData && !r_write;
    assign w_rxFlush   = w_complete && w_isCtrl && r_write && bus.HWDATA[1];

    assign w_txLevel   = 8'(r_txCount);
    assign w_rxLevel   = 8'(r_rxCount);
    assign w_status    = {8'h00, w_rxLevel, w_txLevel, 4'h0, w_rxFull, w_rxEmpty, w_txFull, w_txEmpty};

    // Only DATA accesses can stall; their readiness comes from the registered FIFO counts.
    always_comb begin
        w_ready = 1'b1;
        w_resp  = 1'b0;
        unique case (r_state)
            S_DPHASE, S_WAIT: begin
                if (w_isData) begin
                    w_ready = r_write ? !w_txFull : !w_rxEmpty;
                end
            end
            S_ERR1: begin
                w_ready = 1'b0;
                w_resp  = 1'b1;
            end
            S_ERR2: w_resp = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        w_rdata = '0;
        if (w_complete && !r_write) begin
            if (w_isData) begin
                w_rdata = r_rxMem[r_rxRd];
            end else if (w_isStatus) begin
                w_rdata = w_status;
            end else if (!w_isCtrl) begin
                w_rdata = 32'hDEAD_BEEF;
            end
        end
    end

    // A badly sized DATA access skips the data phase and goes straight into the error response.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_write   <= 1'b0;
            r_size    <= '0;
            r_waitCnt <= '0;
        end else if (r_state == S_ERR1) begin
            r_state <= S_ERR2;
        end else if (w_dataPhase && !w_ready) begin
            r_waitCnt <= w_waitNext;
            r_state   <= (w_waitNext == TIMEOUT_CNT) ? S_ERR1 : S_WAIT;
        end else if (w_capture) begin
            r_addr    <= bus.HADDR[7:0];
            r_write   <= bus.HWRITE;
            r_size    <= bus.HSIZE;
            r_waitCnt <= '0;
            r_state   <= w_badSize ? S_ERR1 : S_DPHASE;
        end else begin
            r_state <= S_IDLE;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_txRd    <= '0;
            r_txWr    <= '0;
            r_txCount <= '0;
        end else if (w_txFlush) begin
            r_txRd    <= '0;
            r_txWr    <= '0;
            r_txCount <= '0;
        end else begin
            if (w_txPush) begin
                r_txWr <= r_txWr + AW'(1);
            end
            if (w_txPop) begin
                r_txRd <= r_txRd + AW'(1);
            end
            if (w_txPush && !w_txPop) begin
                r_txCount <= r_txCount + CW'(1);
            end else if (!w_txPush && w_txPop) begin
                r_txCount <= r_txCount - CW'(1);
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_rxRd    <= '0;
            r_rxWr    <= '0;
            r_rxCount <= '0;
        end else if (w_rxFlush) begin
            r_rxRd    <= '0;
            r_rxWr    <= '0;
            r_rxCount <= '0;
        end else begin
            if (w_rxPush) begin
                r_rxWr <= r_rxWr + AW'(1);
            end
            if (w_rxPop) begin
                r_rxRd <= r_rxRd + AW'(1);
            end
            if (w_rxPush && !w_rxPop) begin
                r_rxCount <= r_rxCount + CW'(1);
            end else if (!w_rxPush && w_rxPop) begin
                r_rxCount <= r_rxCount - CW'(1);
            end
        end
    end

    // Storage arrays carry no reset; the pointers and counts define which entries are live.
    always_ff @(posedge HCLK) begin
        if (w_txPush) begin
            r_txMem[r_txWr] <= bus.HWDATA;
        end
        if (w_rxPush) begin
            r_rxMem[r_rxWr] <= bus.rx_data;
        end
    end

    assign bus.HREADYOUT = w_ready;
    assign bus.HRESP     = w_resp;
    assign bus.HRDATA    = w_rdata;
    assign bus.tx_data   = r_txMem[r_txRd];
    assign bus.tx_valid  = !w_txEmpty;
    assign bus.rx_ready  = !w_rxFull;
endmodule

// File: tb/tb_ahbl_stream_slave.sv
// Directed plus randomized bench for ahbl_stream_slave, checked against queue-based FIFO models.
// Single responder system: HREADY is looped back from HREADYOUT.
module tb_ahbl_stream_slave;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 16;
    localparam int BOUND   = 300;
    localparam logic [2:0] WORD = 3'd2;

    logic clock = 1'b0;
    logic resetN;
    int   assertCount = 0;
    int   failCount   = 0;
    logic [31:0] txModel[$];
    logic [31:0] rxModel[$];

    ahbl_stream_slave_if bus ();
    assign bus.HREADY = bus.HREADYOUT;

    ahbl_stream_slave #(
        .DEPTH(DEPTH),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .HCLK(clock),
        .HRESETn(resetN),
        .bus(bus.slave)
    );

    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] modelStatus();
        int t;
        int r;
        t = txModel.size();
        r = rxModel.size();
        return {8'h00, 8'(r), 8'(t), 4'h0, r == DEPTH, r == 0, t == DEPTH, t == 0};
    endfunction

    // One non-pipelined transfer; optionally pulses tx_ready or rx_valid in data-phase cycle pulseAt.
    task automatic applyStimulus(
        input  logic [31:0] addr, input logic wr, input logic [2:0] size, input logic [31:0] wdata,
        input  int pulseAt, input logic pulseRx, input logic [31:0] pulseData,
        output int waits, output logic [31:0] rdata, output logic resp, output logic lastWaitResp);
        int   k;
        logic done;
        bus.HSEL   = 1'b1;
        bus.HTRANS = 2'b10;
        bus.HADDR  = addr;
        bus.HWRITE = wr;
        bus.HSIZE  = size;
        @(posedge clock);
        #1;
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
        bus.HWDATA = wdata;
        waits = 0;
        rdata = '0;
        resp = 1'b0;
        lastWaitResp = 1'b0;
        done = 1'b0;
        k = 1;
        while (!done && k <= BOUND) begin
            if (k == pulseAt) begin
                if (pulseRx) begin
                    bus.rx_valid = 1'b1;
                    bus.rx_data  = pulseData;
                end else begin
                    bus.tx_ready = 1'b1;
                end
            end
            @(negedge clock);
            if (bus.HREADYOUT) begin
                done  = 1'b1;
                rdata = bus.HRDATA;
                resp  = bus.HRESP;
            end else begin
                waits++;
                lastWaitResp = bus.HRESP;
            end
            @(posedge clock);
            #1;
            bus.rx_valid = 1'b0;
            bus.tx_ready = 1'b0;
            k++;
        end
        checkOutput("handshakeBound", 32'(done), 32'd1);
    endtask

    task automatic runTransfer(
        input string tag, input logic [31:0] addr, input logic wr, input logic [2:0] size,
        input logic [31:0] wdata, input int pulseAt, input logic pulseRx, input logic [31:0] pulseData,
        input int expWaits, input logic [31:0] expRdata, input logic expResp);
        int          waits;
        logic [31:0] rdata;
        logic        resp;
        logic        lastWaitResp;
        applyStimulus(addr, wr, size, wdata, pulseAt, pulseRx, pulseData, waits, rdata, resp, lastWaitResp);
        checkOutput({tag, ".waits"}, 32'(waits), 32'(expWaits));
        checkOutput({tag, ".hrdata"}, rdata, expRdata);
        checkOutput({tag, ".hresp"}, 32'(resp), 32'(expResp));
        if (expWaits > 0) begin
            checkOutput({tag, ".lastWaitHresp"}, 32'(lastWaitResp), 32'(expResp));
        end
    endtask

    task automatic pushRx(input logic [31:0] data);
        logic room;
        room = (rxModel.size() < DEPTH);
        bus.rx_valid = 1'b1;
        bus.rx_data  = data;
        @(negedge clock);
        checkOutput("rxReady", 32'(bus.rx_ready), 32'(room));
        if (room) begin
            rxModel.push_back(data);
        end
        @(posedge clock);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic drainTx(input int n);
        bus.tx_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            checkOutput("txValidDrain", 32'(bus.tx_valid), 32'd1);
            checkOutput("txDataDrain", bus.tx_data, txModel[0]);
            void'(txModel.pop_front());
            @(posedge clock);
            #1;
        end
        bus.tx_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] word;
        logic [31:0] expData;
        logic [1:0]  bits;
        int          pulse;
        int          op;

        resetN       = 1'b0;
        bus.HSEL     = 1'b0;
        bus.HADDR    = '0;
        bus.HTRANS   = 2'b00;
        bus.HWRITE   = 1'b0;
        bus.HSIZE    = WORD;
        bus.HWDATA   = '0;
        bus.tx_ready = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checkOutput("resetHreadyout", 32'(bus.HREADYOUT), 32'd1);
        checkOutput("resetHresp", 32'(bus.HRESP), 32'd0);
        checkOutput("resetTxValid", 32'(bus.tx_valid), 32'd0);
        checkOutput("resetRxReady", 32'(bus.rx_ready), 32'd1);
        checkOutput("resetHrdata", bus.HRDATA, 32'd0);
        resetN = 1'b1;

        runTransfer("statusInit", 32'h04, 1'b0, WORD, 32'd0, 0, 1'b0, 32'd0, 0, modelStatus(), 1'b0);

        for (int i = 0; i < DEPTH; i++) begin
            word = $urandom;
            runTransfer("txWrite", 32'h00, 1'b1, WORD, word, 0, 1'b0, 32'd0, 0, 32'd0, 1'b0);
            txModel.push_back(word);
        end
        runTransfer("statusTxFull", 32'h04, 1'b0, WORD, 32'd0, 0, 1'b0, 32'd0, 0, modelStatus(), 1'b0);
        @(negedge clock);
        checkOutput("txValidFull", 32'(bus.tx_valid), 32'd1);
        checkOutput("txDataHead", bus.tx_data, txModel[0]);
        @(posedge clock);
        #1;

        word = $urandom;
        runTransfer("txWriteWhileFull", 32'h00, 1'b1, WORD, word, 3, 1'b0, 32'd0, 3, 32'd0, 1'b0);
        void'(txModel.pop_front());
        txModel.push_back(word);
        drainTx(DEPTH);
        @(negedge clock);
        checkOutput("txValidDrained", 32'(bus.tx_valid), 32'd0);
        @(posedge clock);
        #1;

        runTransfer("rxReadTimeout", 32'h00, 1'b0, WORD, 32'd0, 0, 1'b0, 32'd0, TIMEOUT + 1, 32'd0, 1'b1);
        runTransfer("statusAfterTimeout", 32'h04, 1'b0, WORD, 32'd0, 0, 1'b0, 32'd0, 0, modelStatus(), 1'b0);

        runTransfer("rxReadLatePush", 32'h00, 1'b0, WORD, 32'd0, 2, 1'b1, 32'hA5A5_0001, 2, 32'hA5A5_0001, 1'b0);
        pulse = $urandom_range(1, 6);
        word  = $urandom;
        runTransfer("rxReadRandomPush", 32'h00, 1'b0, WORD, 32'd0, pulse, 1'b1, word, pulse, word, 1'b0);
        runTransfer("statusRxBackEmpty", 32'h04, 1'b0, WORD, 32'd0, 0, 1'b0, 32'd0, 0, modelStatus(), 1'b0);

        word = $urandom;
        runTransfer("txWriteSingle", 32'h00, 1'b1, WORD, word, 0, 1'b0, 32'd0, 0, 32'd0, 1'b0);
        txModel.push_back(word);
        runTransfer("byteWrite", 32'h00, 1'b1, 3'd0, $urandom, 0, 1'b0, 32'd0, 1, 32'd0, 1'b1);
        runTransfer("halfRead", 32'h00, 1'b0, 3'd1, 32'd0, 0, 1'b0, 32'd0, 1, 32'd0, 1'b1);
        runTransfer("unmappedRead", 32'h20, 1'b0, WORD, 32'd0, 0, 1'b0, 32'd0, 0, 32'hDEAD_BEEF, 1'b0);
        runTransfer("unmappedWrite", 32'h30, 1'b1, WORD, $urandom, 0, 1'b0, 32'd0, 0, 32'd0, 1'b0);
        runTransfer("ctrlRead", 32'h08, 1'b0, WORD, 32'd0, 0, 1'b0, 32'd0, 0, 32'd0, 1'b0);
        runTransfer("statusAfterByte", 32'h04, 1'b0, WORD, 32'd0, 0, 1'b0, 32'd0, 0, modelStatus(), 1'b0);

        for (int i = 0; i < 2; i++) begin
            word = $urandom;
            runTransfer("txFillThree", 32'h00, 1'b1, WORD, word, 0, 1'b0, 32'd0, 0, 32'd0, 1'b0);
            txModel.push_back(word);
        end
        for (int i = 0; i < 3; i++) begin
            pushRx($urandom);
        end
        runTransfer("statusThreeThree", 32'h04, 1'b0, WORD, 32'd0, 0, 1'b0, 32'd0, 0, modelStatus(), 1'b0);
        runTransfer("ctrlFlushBoth", 32'h08, 1'b1, WORD, 32'h3, 0, 1'b0, 32'd0, 0, 32'd0, 1'b0);
        txModel.delete();
        rxModel.delete();
        @(negedge clock);
        checkOutput("txValidAfterFlush", 32'(bus.tx_valid), 32'd0);
        checkOutput("rxReadyAfterFlush", 32'(bus.rx_ready), 32'd1);
        runTransfer("statusAfterFlush", 32'h04, 1'b0, WORD, 32'd0, 0, 1'b0, 32'd0, 0, modelStatus(), 1'b0);

        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 5);
            case (op)
                0: begin
                    word = $urandom;
                    if (txModel.size() < DEPTH) begin
                        runTransfer("rndWrite", 32'h00, 1'b1, WORD, word, 0, 1'b0, 32'd0, 0, 32'd0, 1'b0);
                        txModel.push_back(word);
                    end else begin
                        runTransfer("rndWriteFull", 32'h00, 1'b1, WORD, word, 0, 1'b0, 32'd0, TIMEOUT + 1, 32'd0, 1'b1);
                    end
                end
                1: pushRx($urandom);
                2: begin
                    if (rxModel.size() > 0) begin
                        expData = rxModel.pop_front();
                        runTransfer("rndRead", 32'h00, 1'b0, WORD, 32'd0, 0, 1'b0, 32'd0, 0, expData, 1'b0);
                    end else begin
                        runTransfer("rndReadEmpty", 32'h00, 1'b0, WORD, 32'd0, 0, 1'b0, 32'd0, TIMEOUT + 1, 32'd0, 1'b1);
                    end
                end
                3: runTransfer("rndStatus", 32'h04, 1'b0, WORD, 32'd0, 0, 1'b0, 32'd0, 0, modelStatus(), 1'b0);
                4: drainTx((txModel.size() < 3) ? txModel.size() : $urandom_range(1, 3));
                default: begin
                    bits = 2'($urandom_range(0, 3));
                    runTransfer("rndCtrl", 32'h08, 1'b1, WORD, {30'd0, bits}, 0, 1'b0, 32'd0, 0, 32'd0, 1'b0);
                    if (bits[0]) txModel.delete();
                    if (bits[1]) rxModel.delete();
                end
            endcase
        end
        runTransfer("statusAfterRandom", 32'h04, 1'b0, WORD, 32'd0, 0, 1'b0, 32'd0, 0, modelStatus(), 1'b0);

        while (txModel.size() < DEPTH) begin
            word = $urandom;
            runTransfer("txRefill", 32'h00, 1'b1, WORD, word, 0, 1'b0, 32'd0, 0, 32'd0, 1'b0);
            txModel.push_back(word);
        end
        bus.HSEL   = 1'b1;
        bus.HTRANS = 2'b10;
        bus.HADDR  = 32'h00;
        bus.HWRITE = 1'b1;
        bus.HSIZE  = WORD;
        @(posedge clock);
        #1;
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
        bus.HWDATA = $urandom;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checkOutput("stallBeforeReset", 32'(bus.HREADYOUT), 32'd0);
        resetN = 1'b0;
        #1;
        txModel.delete();
        rxModel.delete();
        checkOutput("midResetHreadyout", 32'(bus.HREADYOUT), 32'd1);
        checkOutput("midResetTxValid", 32'(bus.tx_valid), 32'd0);
        checkOutput("midResetHresp", 32'(bus.HRESP), 32'd0);
        @(negedge clock);
        resetN = 1'b1;
        runTransfer("statusAfterRelease", 32'h04, 1'b0, WORD, 32'd0, 0, 1'b0, 32'd0, 0, modelStatus(), 1'b0);
        word = $urandom;
        runTransfer("writeAfterRelease", 32'h00, 1'b1, WORD, word, 0, 1'b0, 32'd0, 0, 32'd0, 1'b0);
        txModel.push_back(word);
        drainTx(1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
